dispatcher: RTL
===============

Name: dispatcher

Overview:
- Sits between the instruction queue/decoder and the execution back end (reservation station, load/store buffer).
- Per instruction: allocates a ROB entry, renames rd in the register file, resolves source operands (register file, ROB ready values, CDB snoop) and hands the packet to the RS or the LSB.
- One-entry holding register decouples the instruction queue from structural stalls in the back end.

Parameters:
- DATA_LEN, 32, operand/immediate width
- ADDR_LEN, 32, pc width
- OPENUM_LEN, 6, internal opcode enum width
- ROB_LEN, 4, ROB tag width; tag 0 reserved as "no dependency / value ready"
- REG_LEN, 5, architectural register index width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rollback  in  1  misprediction flush from ROB
- inst_valid  in  1  decoded instruction available
- openum_in  in  OPENUM_LEN  opcode enum
- is_ls_in  in  1  1 = load/store (route to LSB), 0 = route to RS
- rd_in, rs1_in, rs2_in  in  REG_LEN each  register indices
- imm_in  in  DATA_LEN  immediate
- pc_in  in  ADDR_LEN  instruction pc
- ready_to_iq  out  1  instruction accepted this cycle when high with inst_valid
- rs1_to_reg, rs2_to_reg  out  REG_LEN  combinational register-file read indices (= rs1_in, rs2_in)
- V1_from_reg, V2_from_reg  in  DATA_LEN  register values
- Q1_from_reg, Q2_from_reg  in  ROB_LEN  register rename tags, pre-rename
- Q1_to_rob, Q2_to_rob  out  ROB_LEN  ROB ready-query tags
- Q1_ready_from_rob, Q2_ready_from_rob  in  1  queried ROB entry has its result
- V1_from_rob, V2_from_rob  in  DATA_LEN  queried ROB values
- rob_full  in  1  no free ROB entry
- rob_alloc_id  in  ROB_LEN  tag the next allocation receives, never 0
- ena_to_rob  out  1  allocate ROB entry, combinational
- rd_to_rob  out  REG_LEN  destination register of the allocation
- openum_to_rob  out  OPENUM_LEN  opcode of the allocation
- pc_to_rob  out  ADDR_LEN  pc of the allocation
- ena_rename_to_reg  out  1  rename pulse, combinational
- rd_to_reg  out  REG_LEN  register being renamed
- rob_id_to_reg  out  ROB_LEN  tag written into the register's Q
- cdb_valid  in  1  CDB broadcast valid
- cdb_rob_id  in  ROB_LEN  broadcast tag
- cdb_value  in  DATA_LEN  broadcast value
- rs_full, lsb_full  in  1 each  target full
- ena_to_rs, ena_to_lsb  out  1 each  dispatch strobes
- openum_out, V1_out, V2_out, Q1_out, Q2_out, pc_out, imm_out, rob_id_out  out  matching widths  registered packet, shared by RS and LSB

Behaviour:
- Holding register state: valid, plus the packet fields.
- Reset: valid=0, all registered packet outputs 0. Combinational strobes are therefore 0.
- dispatch = valid && !rollback && (is_ls ? !lsb_full : !rs_full).
- ena_to_rs = dispatch && !is_ls. ena_to_lsb = dispatch && is_ls.
- ready_to_iq = !rst && !rollback && !rob_full && (!valid || dispatch).
- accept = inst_valid && ready_to_iq. On accept, all combinational in the same cycle:
  - ena_to_rob=1.
  - If rd_in!=0: ena_rename_to_reg=1, rd_to_reg=rd_in, rob_id_to_reg=rob_alloc_id.
  - rd=0 never renames.
- Operand resolution at accept, per operand j:
  - If Qj_from_reg==0: V=Vj_from_reg, Q=0.
  - Else if Qj_ready_from_rob: V=Vj_from_rob, Q=0.
  - Else if cdb_valid && cdb_rob_id==Qj_from_reg: V=cdb_value, Q=0.
  - Else: Q=Qj_from_reg.
  - The register file returns pre-rename tags, so rs1==rd self-dependency is handled naturally.
- Edge after accept: register loads the packet with rob_id_out=rob_alloc_id; valid=1.
- Edge with dispatch and no accept: valid=0.
- Edge with dispatch and accept: register reloads (full throughput, one instruction per cycle).
- While held (valid && !dispatch): each edge with cdb_valid && cdb_rob_id==Qj_out (Qj_out!=0) sets Vj_out=cdb_value, Qj_out=0. The same update applies in the dispatch cycle is irrelevant (entry leaves).
- Latency: accept at edge k, packet visible in cycle k+1, dispatched at edge k+1 if target not full.
- rollback: valid cleared at the edge, no strobes that cycle, ready_to_iq=0. Rollback dominates accept and dispatch.
- rst mid-operation: same effect as rollback plus packet zeroed.
- rob_full: blocks accept only; a held entry still dispatches.

Test Plan:
- Reset, then ADDI x1,x0,5 (Q1_from_reg=0, rob_alloc_id=1) -> same cycle ena_to_rob=1, rename x1->1; next cycle ena_to_rs=1, V1_out=0, Q1_out=0, imm_out=5, rob_id_out=1.
- Back-to-back: 4 instructions, inst_valid held, targets never full -> ready_to_iq=1 every cycle, 4 consecutive ena_to_rs pulses, rob_id_out 1,2,3,4.
- rs_full=1 for 3 cycles with held ADD (Q2_out=3); CDB tag 3 value 0x77 in cycle 2 -> ready_to_iq=0 throughout, Q2_out=0 and V2_out=0x77 next cycle, ena_to_rs at rs_full fall.
- Operand sources: Q1_from_reg=2 with Q1_ready_from_rob=1, V1_from_rob=0xAB -> Q1_out=0, V1_out=0xAB. Q2_from_reg=5 matching same-cycle CDB value 9 -> Q2_out=0, V2_out=9.
- Load with lsb_full=1, then rollback=1 -> no ena_to_lsb, valid cleared, ready_to_iq=0 during rollback, no ena_to_rob that cycle.
- rob_full=1 with empty holder -> ready_to_iq=0, no rename. ADDI rd=x0 -> ena_to_rob=1, ena_rename_to_reg=0.

Source files
------------

// File: rtl/dispatcher.sv
// Dispatcher: one-entry holding register between the instruction queue and
// the execution back end. On accept it allocates a ROB entry, renames rd,
// resolves source operands (regfile / ROB / CDB) and latches the packet.
// The held packet is then steered to the RS or the LSB.
module dispatcher #(
    parameter int DATA_LEN   = 32,
    parameter int ADDR_LEN   = 32,
    parameter int OPENUM_LEN = 6,
    parameter int ROB_LEN    = 4,
    parameter int REG_LEN    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rollback,
    // instruction queue / decoder side
    input  logic                  inst_valid,
    input  logic [OPENUM_LEN-1:0] openum_in,
    input  logic                  is_ls_in,
    input  logic [REG_LEN-1:0]    rd_in,
    input  logic [REG_LEN-1:0]    rs1_in,
    input  logic [REG_LEN-1:0]    rs2_in,
    input  logic [DATA_LEN-1:0]   imm_in,
    input  logic [ADDR_LEN-1:0]   pc_in,
    output logic                  ready_to_iq,
    // register file read
    output logic [REG_LEN-1:0]    rs1_to_reg,
    output logic [REG_LEN-1:0]    rs2_to_reg,
    input  logic [DATA_LEN-1:0]   V1_from_reg,
    input  logic [DATA_LEN-1:0]   V2_from_reg,
    input  logic [ROB_LEN-1:0]    Q1_from_reg,
    input  logic [ROB_LEN-1:0]    Q2_from_reg,
    // ROB ready query
    output logic [ROB_LEN-1:0]    Q1_to_rob,
    output logic [ROB_LEN-1:0]    Q2_to_rob,
    input  logic                  Q1_ready_from_rob,
    input  logic                  Q2_ready_from_rob,
    input  logic [DATA_LEN-1:0]   V1_from_rob,
    input  logic [DATA_LEN-1:0]   V2_from_rob,
    // ROB allocation
    input  logic                  rob_full,
    input  logic [ROB_LEN-1:0]    rob_alloc_id,
    output logic                  ena_to_rob,
    output logic [REG_LEN-1:0]    rd_to_rob,
    output logic [OPENUM_LEN-1:0] openum_to_rob,
    output logic [ADDR_LEN-1:0]   pc_to_rob,
    // register rename
    output logic                  ena_rename_to_reg,
    output logic [REG_LEN-1:0]    rd_to_reg,
    output logic [ROB_LEN-1:0]    rob_id_to_reg,
    // common data bus
    input  logic                  cdb_valid,
    input  logic [ROB_LEN-1:0]    cdb_rob_id,
    input  logic [DATA_LEN-1:0]   cdb_value,
    // back end
    input  logic                  rs_full,
    input  logic                  lsb_full,
    output logic                  ena_to_rs,
    output logic                  ena_to_lsb,
    output logic [OPENUM_LEN-1:0] openum_out,
    output logic [DATA_LEN-1:0]   V1_out,
    output logic [DATA_LEN-1:0]   V2_out,
    output logic [ROB_LEN-1:0]    Q1_out,
    output logic [ROB_LEN-1:0]    Q2_out,
    output logic [ADDR_LEN-1:0]   pc_out,
    output logic [DATA_LEN-1:0]   imm_out,
    output logic [ROB_LEN-1:0]    rob_id_out
);

    logic                  r_valid;
    logic                  r_is_ls;
    logic [OPENUM_LEN-1:0] r_openum;
    logic [DATA_LEN-1:0]   r_V1;
    logic [DATA_LEN-1:0]   r_V2;
    logic [ROB_LEN-1:0]    r_Q1;
    logic [ROB_LEN-1:0]    r_Q2;
    logic [ADDR_LEN-1:0]   r_pc;
    logic [DATA_LEN-1:0]   r_imm;
    logic [ROB_LEN-1:0]    r_rob_id;

    logic                  w_dispatch;
    logic                  w_ready;
    logic                  w_accept;
    logic [DATA_LEN-1:0]   w_V1;
    logic [DATA_LEN-1:0]   w_V2;
    logic [ROB_LEN-1:0]    w_Q1;
    logic [ROB_LEN-1:0]    w_Q2;

    // Handshake: dispatch of the held entry and acceptance of a new one
    always_comb begin
        w_dispatch = r_valid && !rst && !rollback && (r_is_ls ? !lsb_full : !rs_full);
        w_ready    = !rst && !rollback && !rob_full && (!r_valid || w_dispatch);
        w_accept   = inst_valid && w_ready;
    end

    // Operand resolution at accept: regfile value, ROB value, then same-cycle CDB
    always_comb begin
        w_V1 = V1_from_reg;
        w_Q1 = '0;
        if (Q1_from_reg != '0) begin
            if (Q1_ready_from_rob)
                w_V1 = V1_from_rob;
            else if (cdb_valid && cdb_rob_id == Q1_from_reg)
                w_V1 = cdb_value;
            else
                w_Q1 = Q1_from_reg;
        end
        w_V2 = V2_from_reg;
        w_Q2 = '0;
        if (Q2_from_reg != '0) begin
            if (Q2_ready_from_rob)
                w_V2 = V2_from_rob;
            else if (cdb_valid && cdb_rob_id == Q2_from_reg)
                w_V2 = cdb_value;
            else
                w_Q2 = Q2_from_reg;
        end
    end

    // Combinational side-band outputs: lookups, ROB allocation, rename, strobes
    always_comb begin
        ready_to_iq       = w_ready;
        rs1_to_reg        = rs1_in;
        rs2_to_reg        = rs2_in;
        Q1_to_rob         = Q1_from_reg;
        Q2_to_rob         = Q2_from_reg;
        ena_to_rob        = w_accept;
        rd_to_rob         = rd_in;
        openum_to_rob     = openum_in;
        pc_to_rob         = pc_in;
        ena_rename_to_reg = w_accept && (rd_in != '0);
        rd_to_reg         = rd_in;
        rob_id_to_reg     = rob_alloc_id;
        ena_to_rs         = w_dispatch && !r_is_ls;
        ena_to_lsb        = w_dispatch && r_is_ls;
    end

    // Holding register: reload on accept, drain on dispatch, snoop CDB while held
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_is_ls  <= 1'b0;
            r_openum <= '0;
            r_V1     <= '0;
            r_V2     <= '0;
            r_Q1     <= '0;
            r_Q2     <= '0;
            r_pc     <= '0;
            r_imm    <= '0;
            r_rob_id <= '0;
        end else if (rollback) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_is_ls  <= is_ls_in;
            r_openum <= openum_in;
            r_V1     <= w_V1;
            r_V2     <= w_V2;
            r_Q1     <= w_Q1;
            r_Q2     <= w_Q2;
            r_pc     <= pc_in;
            r_imm    <= imm_in;
            r_rob_id <= rob_alloc_id;
        end else if (w_dispatch) begin
            r_valid <= 1'b0;
        end else if (r_valid && cdb_valid) begin
            if (r_Q1 != '0 && cdb_rob_id == r_Q1) begin
                r_V1 <= cdb_value;
                r_Q1 <= '0;
            end
            if (r_Q2 != '0 && cdb_rob_id == r_Q2) begin
                r_V2 <= cdb_value;
                r_Q2 <= '0;
            end
        end
    end

    // Registered packet, shared by RS and LSB
    always_comb begin
        openum_out = r_openum;
        V1_out     = r_V1;
        V2_out     = r_V2;
        Q1_out     = r_Q1;
        Q2_out     = r_Q2;
        pc_out     = r_pc;
        imm_out    = r_imm;
        rob_id_out = r_rob_id;
    end

endmodule
